// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped down-counting timer: register offsets,
// CTRL field positions, FSM encoding and mode values.
package timer_counter_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_RSVD   = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  // Modes 2 and 3 behave as one-shot.
  function automatic logic is_periodic(input logic [1:0] mode);
    return mode == MODE_PERIODIC;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Timer/counter responder on the CPU load/store port: CTRL/PRESET/COUNT registers,
// a four-state reload/count FSM and a maskable level interrupt.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Sel,
  input  logic [31:0] MemAddr,
  input  logic        MemWrite,
  input  logic [31:0] MemData,
  output logic [31:0] MemReadData,
  output logic        IRQ,
  output logic [1:0]  dbg_state_o
);

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  state_q, state_d;
  logic        irq_q, irq_d;

  logic [1:0]  addr;
  logic        wr_ctrl, wr_preset;
  logic        set_irq, clr_irq, drop_en;
  logic        unused_addr;

  assign addr        = MemAddr[3:2];
  assign unused_addr = ^{MemAddr[31:4], MemAddr[1:0]};
  assign wr_ctrl     = Sel & MemWrite & (addr == TC_CTRL);
  assign wr_preset   = Sel & MemWrite & (addr == TC_PRESET);

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    state_d  = state_q;
    irq_d    = irq_q;
    set_irq  = 1'b0;
    clr_irq  = 1'b0;
    drop_en  = 1'b0;

    case (state_q)
      ST_IDLE: if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // COUNT of 0 or 1 both expire here, so it never wraps.
          count_d = 32'd0;
          set_irq = 1'b1;
          state_d = ST_INT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (is_periodic(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB])) clr_irq = 1'b1;
        else drop_en = 1'b1;
      end
    endcase

    // A CPU write to CTRL overrides the FSM's own Enable clear.
    if (wr_ctrl) ctrl_d = MemData[3:0];
    else if (drop_en) ctrl_d[CTRL_EN] = 1'b0;

    if (wr_preset) preset_d = MemData;

    // Setting the flag beats any clear landing on the same edge.
    if (set_irq) begin
      irq_d = 1'b1;
    end else if (clr_irq ||
                 (!is_periodic(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]) && (wr_ctrl || wr_preset))) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      state_q  <= state_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    MemReadData = 32'd0;
    if (Sel) begin
      case (addr)
        TC_CTRL:   MemReadData = {28'd0, ctrl_q};
        TC_PRESET: MemReadData = preset_q;
        TC_COUNT:  MemReadData = count_q;
        TC_RSVD:   MemReadData = 32'd0;
        default:   MemReadData = 32'd0;
      endcase
    end
  end

  assign IRQ         = ctrl_q[CTRL_IM] & irq_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed timing scenarios plus a randomized bus
// sequence checked against a cycle-level behavioural model of the timer.
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic        clk;
  logic        reset;
  logic        Sel;
  logic [31:0] MemAddr;
  logic        MemWrite;
  logic [31:0] MemData;
  logic [31:0] MemReadData;
  logic        IRQ;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  timer_counter dut (
    .clk         (clk),
    .reset       (reset),
    .Sel         (Sel),
    .MemAddr     (MemAddr),
    .MemWrite    (MemWrite),
    .MemData     (MemData),
    .MemReadData (MemReadData),
    .IRQ         (IRQ),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_DONE = 3;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  int          m_phase;
  logic        m_irq;

  task automatic model_clear();
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_phase = P_IDLE; m_irq = 1'b0;
  endtask

  task automatic model_step(input logic sel, input logic we, input logic [31:0] addr,
                            input logic [31:0] data);
    bit wc, wp, fire, unfire, stop, oneshot;
    int nxt;
    wc = sel && we && (addr[3:2] == 2'd0);
    wp = sel && we && (addr[3:2] == 2'd1);
    oneshot = (m_ctrl[2:1] != 2'd1);
    fire = 0; unfire = 0; stop = 0; nxt = m_phase;
    if (m_phase == P_IDLE) begin
      if (m_ctrl[0]) nxt = P_ARM;
    end else if (m_phase == P_ARM) begin
      m_count = m_preset; nxt = P_RUN;
    end else if (m_phase == P_RUN) begin
      if (!m_ctrl[0]) nxt = P_IDLE;
      else if (m_count > 1) m_count = m_count - 1;
      else begin m_count = 0; fire = 1; nxt = P_DONE; end
    end else begin
      nxt = P_IDLE;
      if (oneshot) stop = 1; else unfire = 1;
    end
    m_phase = nxt;
    if (wc) m_ctrl = data[3:0];
    else if (stop) m_ctrl[0] = 1'b0;
    if (wp) m_preset = data;
    if (fire) m_irq = 1'b1;
    else if (unfire || (oneshot && (wc || wp))) m_irq = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] off);
    case (off)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] model_state();
    case (m_phase)
      P_IDLE:  return ST_IDLE;
      P_ARM:   return ST_LOAD;
      P_RUN:   return ST_CNT;
      default: return ST_INT;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // One bus cycle: inputs change at negedge, model follows the posedge.
  task automatic bus(input logic sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] data);
    @(negedge clk);
    Sel = sel; MemWrite = we; MemAddr = addr; MemData = data;
    @(posedge clk);
    model_step(sel, we, addr, data);
    #1;
    Sel = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] d);
    Sel = 1'b1; MemWrite = 1'b0; MemAddr = {28'd0, off};
    #1;
    d = MemReadData;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0; Sel = 1'b0; MemWrite = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    #1;
    n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    @(negedge clk); reset = 1'b1;
    for (int off = 0; off < 16; off += 4) begin
      rd(off[3:0], d);
      n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_read off=%0d got=%h exp=0", off, d); end
    end
    Sel = 1'b0; #1;
    n_tests++; if (MemReadData !== 32'd0) begin n_fail++; $display("FAIL unsel_read got=%h exp=0", MemReadData); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    reset_dut();
    bus(1, 1, 32'h4, 32'd3);
    bus(1, 1, 32'h0, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      idle();
      rd(4'h8, d);
      n_tests++;
      if (d !== ((k < 2) ? 32'd0 : (k <= 5) ? 32'(5 - k) : 32'd0)) begin
        n_fail++; $display("FAIL oneshot_count k=%0d got=%0d", k, d);
      end
      n_tests++; if (IRQ !== (k >= 5)) begin n_fail++; $display("FAIL oneshot_irq k=%0d got=%b exp=%b", k, IRQ, k >= 5); end
    end
    rd(4'h0, d);
    n_tests++; if (d !== 32'h8) begin n_fail++; $display("FAIL oneshot_ctrl got=%h exp=8", d); end
    bus(1, 1, 32'h4, 32'd3);
    n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clear got=%b exp=0", IRQ); end
  endtask

  task automatic test_periodic();
    logic [31:0] d;
    reset_dut();
    bus(1, 1, 32'h4, 32'd2);
    bus(1, 1, 32'h0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      idle();
      n_tests++;
      if (IRQ !== ((k >= 4) && ((k - 4) % 5 == 0))) begin
        n_fail++; $display("FAIL periodic_irq k=%0d got=%b", k, IRQ);
      end
      rd(4'h0, d);
      n_tests++; if (d !== 32'hB) begin n_fail++; $display("FAIL periodic_ctrl k=%0d got=%h exp=b", k, d); end
    end
  endtask

  task automatic test_masked_expire();
    logic [31:0] d;
    reset_dut();
    bus(1, 1, 32'h4, 32'd1);
    bus(1, 1, 32'h0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      idle();
      n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL masked_irq k=%0d got=%b exp=0", k, IRQ); end
    end
    rd(4'h0, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL masked_ctrl got=%h exp=0", d); end
    bus(1, 1, 32'h0, 32'h8);
    n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL masked_write_clears got=%b exp=0", IRQ); end
    // Unmask on the very edge the count expires: the set wins over the write's clear.
    reset_dut();
    bus(1, 1, 32'h4, 32'd1);
    bus(1, 1, 32'h0, 32'h1);
    idle();
    idle();
    n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL race_pre got=%b exp=0", IRQ); end
    bus(1, 1, 32'h0, 32'h8);
    n_tests++; if (dbg_state !== ST_INT) begin n_fail++; $display("FAIL race_state got=%0d exp=%0d", dbg_state, ST_INT); end
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL race_irq k=%0d got=%b exp=1", k, IRQ); end
      idle();
    end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL race_idle got=%0d exp=%0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    reset_dut();
    bus(1, 1, 32'h4, 32'd1);
    bus(1, 1, 32'h0, 32'h9);
    idle(); idle(); idle();
    n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL b2b_irq got=%b exp=1", IRQ); end
    bus(1, 1, 32'h0, 32'h9);
    rd(4'h0, d);
    n_tests++; if (d !== 32'h9) begin n_fail++; $display("FAIL b2b_ctrl got=%h exp=9", d); end
    n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL b2b_irq_clr got=%b exp=0", IRQ); end
    idle();
    n_tests++; if (dbg_state !== ST_LOAD) begin n_fail++; $display("FAIL b2b_load got=%0d exp=%0d", dbg_state, ST_LOAD); end
    idle();
    n_tests++; if (dbg_state !== ST_CNT) begin n_fail++; $display("FAIL b2b_cnt got=%0d exp=%0d", dbg_state, ST_CNT); end
    idle();
    n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL b2b_irq2 got=%b exp=1", IRQ); end
  endtask

  task automatic test_ignored_writes();
    logic [31:0] d;
    reset_dut();
    bus(1, 1, 32'h4, 32'd5);
    bus(1, 1, 32'h0, 32'h1);
    idle(); idle(); idle();
    bus(1, 1, 32'h0, 32'h0);
    idle();
    rd(4'h8, d);
    n_tests++; if (d !== 32'd3) begin n_fail++; $display("FAIL ign_count0 got=%0d exp=3", d); end
    bus(1, 1, 32'h8, 32'hFFFF);
    rd(4'h8, d);
    n_tests++; if (d !== 32'd3) begin n_fail++; $display("FAIL ign_count_wr got=%0d exp=3", d); end
    bus(1, 1, 32'hC, 32'h123);
    rd(4'hC, d);
    n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL ign_rsvd got=%h exp=0", d); end
    bus(0, 1, 32'h4, 32'hAAAA);
    rd(4'h4, d);
    n_tests++; if (d !== 32'd5) begin n_fail++; $display("FAIL ign_unsel_preset got=%h exp=5", d); end
    bus(0, 1, 32'h0, 32'hF);
    rd(4'h0, d);
    n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL ign_unsel_ctrl got=%h exp=0", d); end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL ign_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_disable_midcount();
    logic [31:0] d;
    reset_dut();
    bus(1, 1, 32'h4, 32'd6);
    bus(1, 1, 32'h0, 32'h1);
    idle(); idle();
    bus(1, 1, 32'h4, 32'd9);
    bus(1, 1, 32'h0, 32'h8);
    for (int k = 0; k < 4; k++) begin
      rd(4'h8, d);
      n_tests++; if (d !== 32'd4) begin n_fail++; $display("FAIL dis_hold k=%0d got=%0d exp=4", k, d); end
      idle();
    end
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL dis_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    bus(1, 1, 32'h0, 32'h1);
    idle();
    idle();
    rd(4'h8, d);
    n_tests++; if (d !== 32'd9) begin n_fail++; $display("FAIL dis_reload got=%0d exp=9", d); end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d;
    reset_dut();
    bus(1, 1, 32'h4, 32'd8);
    bus(1, 1, 32'h0, 32'h9);
    for (int k = 0; k < 5; k++) idle();
    rd(4'h8, d);
    n_tests++; if (d !== 32'd5) begin n_fail++; $display("FAIL rstmid_pre got=%0d exp=5", d); end
    reset = 1'b0; model_clear(); #1;
    n_tests++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    rd(4'h8, d);
    n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=0", d); end
    @(negedge clk); reset = 1'b1;
    for (int off = 0; off < 12; off += 4) begin
      rd(off[3:0], d);
      n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL rstmid_read off=%0d got=%h exp=0", off, d); end
    end
    // PRESET=0 expires like PRESET=1; then reset while IRQ is high.
    bus(1, 1, 32'h0, 32'h9);
    idle(); idle();
    n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL p0_early got=%b exp=0", IRQ); end
    idle();
    n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL p0_fire got=%b exp=1", IRQ); end
    reset = 1'b0; model_clear(); #1;
    n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", IRQ); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] d, addr, data, exp;
    logic [1:0]  off;
    logic        sel, we;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      sel = ($urandom_range(0, 99) < 85);
      we  = ($urandom_range(0, 99) < 15);
      off = 2'($urandom_range(0, 3));
      case (off)
        2'd0:    data = {$urandom() & 32'hFFFF_FFF0, 28'd0, 4'($urandom_range(0, 15))} ;
        2'd1:    data = 32'($urandom_range(0, 6));
        default: data = $urandom();
      endcase
      addr = ($urandom() & 32'hFFFF_FFF3) | {28'd0, off, 2'b00};
      bus(sel, we, addr, data);
      n_tests++;
      if (IRQ !== (m_ctrl[3] & m_irq)) begin
        n_fail++; $display("FAIL rand_irq i=%0d got=%b exp=%b", i, IRQ, m_ctrl[3] & m_irq);
      end
      n_tests++;
      if (dbg_state !== model_state()) begin
        n_fail++; $display("FAIL rand_state i=%0d got=%0d exp=%0d", i, dbg_state, model_state());
      end
      off = 2'($urandom_range(0, 3));
      exp_q.push_back(model_read(off));
      rd({off, 2'b00}, d);
      exp = exp_q.pop_front();
      n_tests++;
      if (d !== exp) begin n_fail++; $display("FAIL rand_read i=%0d off=%0d got=%h exp=%h", i, off, d, exp); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0; Sel = 1'b0; MemWrite = 1'b0; MemAddr = 32'd0; MemData = 32'd0;
    model_clear();
    test_reset();
    test_oneshot();
    test_periodic();
    test_masked_expire();
    test_back_to_back();
    test_ignored_writes();
    test_disable_midcount();
    test_reset_midcount();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
